// File: rtl/emulib_rammodel_req_sched.sv
// Request scheduler between the rammodel frontend AXI slave and the backend
// memory port. Orders AR/AW/W so no read goes out while a write burst is open,
// arbitrates read vs write (read priority with a starvation guard) and caps
// the number of outstanding bursts. Only handshakes and AWLEN pass through.
//
// Handshakes: a transfer fires when valid and ready are both high on a rising
// clk edge. Grants depend only on registered state and up_*valid (never on
// dn_*ready), and a presented dn_*valid is held by a lock until it fires.
module emulib_rammodel_req_sched #(
   parameter int MAX_R_INFLIGHT = 8,
   parameter int MAX_W_INFLIGHT = 8,
   parameter int MAX_RD_STREAK  = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                up_arvalid,
   output logic                                up_arready,
   input  logic                                up_awvalid,
   output logic                                up_awready,
   input  logic [7:0]                          up_awlen,
   input  logic                                up_wvalid,
   output logic                                up_wready,
   input  logic                                up_wlast,
   output logic                                dn_arvalid,
   input  logic                                dn_arready,
   output logic                                dn_awvalid,
   input  logic                                dn_awready,
   output logic                                dn_wvalid,
   input  logic                                dn_wready,
   input  logic                                rdone,
   input  logic                                bdone,
   output logic [$clog2(MAX_R_INFLIGHT+1)-1:0] r_inflight,
   output logic [$clog2(MAX_W_INFLIGHT+1)-1:0] w_inflight,
   output logic                                busy,
   output logic                                wlast_err
);

   localparam int RW = $clog2(MAX_R_INFLIGHT+1);
   localparam int WW = $clog2(MAX_W_INFLIGHT+1);
   localparam int SW = $clog2(MAX_RD_STREAK+1);

   typedef enum logic {IDLE = 1'b0, WDATA = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [7:0]    beat_cnt, beat_nxt;
   logic          err_nxt;
   logic [SW-1:0] streak;
   logic          ar_lock, aw_lock;
   logic          grant_r, grant_w;
   logic          r_ok, w_ok;
   logic          ar_fire, aw_fire, w_fire;
   logic          r_dec, w_dec;

   assign r_ok = r_inflight < RW'(MAX_R_INFLIGHT);
   assign w_ok = w_inflight < WW'(MAX_W_INFLIGHT);

   // Arbitration in IDLE: locks first, then read priority unless the read
   // streak has reached its limit while a write waits.
   always_comb begin
      grant_r = 1'b0;
      grant_w = 1'b0;
      if (rst_n && state == IDLE) begin
         if (ar_lock) begin
            grant_r = 1'b1;
         end else if (aw_lock) begin
            grant_w = 1'b1;
         end else if (up_arvalid && r_ok && up_awvalid && w_ok) begin
            if (streak == SW'(MAX_RD_STREAK)) grant_w = 1'b1;
            else                              grant_r = 1'b1;
         end else if (up_arvalid && r_ok) begin
            grant_r = 1'b1;
         end else if (up_awvalid && w_ok) begin
            grant_w = 1'b1;
         end
      end
   end

   assign dn_arvalid = up_arvalid & grant_r;
   assign up_arready = dn_arready & grant_r;
   assign dn_awvalid = up_awvalid & grant_w;
   assign up_awready = dn_awready & grant_w;
   assign dn_wvalid  = (state == WDATA) & up_wvalid;
   assign up_wready  = (state == WDATA) & dn_wready;

   assign ar_fire = dn_arvalid & dn_arready;
   assign aw_fire = dn_awvalid & dn_awready;
   assign w_fire  = dn_wvalid & dn_wready;
   assign r_dec   = rdone & (r_inflight != '0);
   assign w_dec   = bdone & (w_inflight != '0);

   assign busy = (state == WDATA) | (r_inflight != '0) | (w_inflight != '0);

   // Next state, beat counter and WLAST consistency check.
   always_comb begin
      state_nxt = state;
      beat_nxt  = beat_cnt;
      err_nxt   = wlast_err;
      case (state)
         IDLE: begin
            if (aw_fire) begin
               state_nxt = WDATA;
               beat_nxt  = up_awlen;
            end
         end
         WDATA: begin
            if (w_fire) begin
               if (up_wlast) begin
                  if (beat_cnt != 8'd0) err_nxt = 1'b1;
                  state_nxt = IDLE;
               end else if (beat_cnt == 8'd0) begin
                  err_nxt = 1'b1;
               end else begin
                  beat_nxt = beat_cnt - 8'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register with beat counter and sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         beat_cnt  <= 8'd0;
         wlast_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         beat_cnt  <= beat_nxt;
         wlast_err <= err_nxt;
      end
   end

   // Locks keep a presented-but-unaccepted request granted until it fires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_lock <= 1'b0;
         aw_lock <= 1'b0;
      end else begin
         if (ar_fire)         ar_lock <= 1'b0;
         else if (dn_arvalid) ar_lock <= 1'b1;
         if (aw_fire)         aw_lock <= 1'b0;
         else if (dn_awvalid) aw_lock <= 1'b1;
      end
   end

   // Read streak: counts reads granted while a write is waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak <= '0;
      end else if (aw_fire || !up_awvalid) begin
         streak <= '0;
      end else if (ar_fire && streak != SW'(MAX_RD_STREAK)) begin
         streak <= streak + SW'(1);
      end
   end

   // Outstanding burst counters; a decrement at zero is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight <= '0;
         w_inflight <= '0;
      end else begin
         case ({ar_fire, r_dec})
            2'b10:   r_inflight <= r_inflight + RW'(1);
            2'b01:   r_inflight <= r_inflight - RW'(1);
            default: r_inflight <= r_inflight;
         endcase
         case ({aw_fire, w_dec})
            2'b10:   w_inflight <= w_inflight + WW'(1);
            2'b01:   w_inflight <= w_inflight - WW'(1);
            default: w_inflight <= w_inflight;
         endcase
      end
   end

endmodule

// File: doc/emulib_rammodel_req_sched.md
Name: emulib_rammodel_req_sched

Overview:
- Request scheduler between the rammodel frontend AXI slave and the backend memory port.
- Sequences AR/AW/W so that no read is issued while a write burst is incomplete, i.e. AW has been sent but W has not finished.
- Arbitrates read vs write with read priority and a starvation guard, and enforces in-flight limits.
- Only handshake and length signals pass through this block; address, ID and data payload bypass it.

Parameters:
- MAX_R_INFLIGHT, 8: maximum outstanding read bursts (AR fired, RLAST not yet done).
- MAX_W_INFLIGHT, 8: maximum outstanding write bursts (AW fired, B not yet done).
- MAX_RD_STREAK, 4: consecutive read grants allowed while a write waits before the write is forced.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- up_arvalid  in  1  frontend read request valid.
- up_arready  out  1  frontend read request ready.
- up_awvalid  in  1  frontend write request valid.
- up_awready  out  1  frontend write request ready.
- up_awlen  in  8  AXI AWLEN of the write request (beats−1).
- up_wvalid  in  1  frontend write data valid.
- up_wready  out  1  frontend write data ready.
- up_wlast  in  1  frontend WLAST.
- dn_arvalid  out  1  backend AR valid.
- dn_arready  in  1  backend AR ready.
- dn_awvalid  out  1  backend AW valid.
- dn_awready  in  1  backend AW ready.
- dn_wvalid  out  1  backend W valid.
- dn_wready  in  1  backend W ready.
- rdone  in  1  one-cycle pulse on backend R fire with RLAST.
- bdone  in  1  one-cycle pulse on backend B fire.
- r_inflight  out  $clog2(MAX_R_INFLIGHT+1)  outstanding reads.
- w_inflight  out  $clog2(MAX_W_INFLIGHT+1)  outstanding writes.
- busy  out  1  high when state is WDATA or either in-flight count is nonzero.
- wlast_err  out  1  sticky: WLAST position disagreed with AWLEN.

Behaviour:
- Reset (async assert, sync deassert use):
  - state=IDLE; counters, streak, locks and wlast_err are 0.
  - All valid/ready outputs are 0; busy=0.
- FSM:
  - IDLE: AR or AW may be granted; W is blocked (up_wready=dn_wvalid=0).
  - IDLE→WDATA on dn AW fire; beat counter is loaded with up_awlen.
  - WDATA: AR and AW are blocked. W passes through: dn_wvalid=up_wvalid, up_wready=dn_wready.
  - Each W fire decrements the beat counter. WDATA→IDLE on W fire with up_wlast=1.
- Grant in IDLE, combinational from registered state plus up_*valid. It never depends on dn_*ready.
  - r_ok = r_inflight<MAX_R_INFLIGHT; w_ok = w_inflight<MAX_W_INFLIGHT.
  - If ar_lock is set, grant R. Else if aw_lock is set, grant W.
  - Else, if both requests are valid and ok: grant W when streak==MAX_RD_STREAK, otherwise grant R.
  - Else grant whichever single request is valid and ok.
  - AR and AW are never granted in the same cycle.
- Pass-through:
  - dn_arvalid = up_arvalid & grant_r; up_arready = dn_arready & grant_r. AW path is identical with grant_w.
  - Zero-cycle latency; no payload registers.
- Locks: ar_lock is set when dn_arvalid & !dn_arready, and cleared on AR fire. aw_lock is the same for AW. This keeps a presented valid stable until it is accepted.
- Streak counter:
  - Increments on AR fire while up_awvalid=1, saturating at MAX_RD_STREAK.
  - Clears on AW fire, or in any cycle with up_awvalid=0.
- In-flight counters:
  - r_inflight += AR fire, −= rdone. w_inflight += AW fire, −= bdone.
  - Simultaneous inc and dec leaves the count unchanged.
  - Underflow (decrement at 0) holds at 0 and sets wlast_err? No: underflow is ignored.
- wlast_err:
  - Set on a W fire where up_wlast != (beat counter==0).
  - On WLAST arriving early: return to IDLE anyway.
  - On a beat arriving after the counter reaches 0 with wlast=0: stay in WDATA; the counter stays at 0.
  - Cleared only by reset.
- Reset mid-burst: returns immediately to IDLE. Counts and locks are lost; the enclosing model resets the backend together with this block.

Test Plan:
- Single read: up_arvalid=1 with dn_arready=1 → dn_arvalid in same cycle, r_inflight=1; rdone pulse → r_inflight=0.
- Write blocks read: AW (awlen=3) fires, then up_arvalid=1 → dn_arvalid stays 0 for all 4 W beats; AR is issued the cycle after the WLAST fire.
- Starvation guard: up_arvalid and up_awvalid both held at 1 → exactly 4 AR grants, then the AW grant; streak clears on the AW fire.
- Lock: AR presented with dn_arready=0 for 3 cycles while up_awvalid rises → dn_arvalid held and AW not granted until AR fires.
- Limits: 8 ARs issued with no rdone → up_arready=0 on the 9th; one rdone → next AR accepted the following cycle. Simultaneous AR fire and rdone at count 8−1 → count unchanged.
- Errors/reset: awlen=1 with WLAST on beat 0 → wlast_err=1, state=IDLE. Assert rst_n=0 during WDATA → outputs 0 immediately and wlast_err=0.
